// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, opcode constants and instruction field positions.
// Fetch forwards instructions undecoded; the decode helpers serve execute and the bench.
package cpu_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    localparam logic [3:0] OP_MOV = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_JMP = 4'h2;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int IMM_HI   = 11;
    localparam int IMM_LO   = 4;
    localparam int SRC_A_HI = 11;
    localparam int SRC_A_LO = 8;
    localparam int SRC_B_HI = 7;
    localparam int SRC_B_LO = 4;
    localparam int DST_HI   = 3;
    localparam int DST_LO   = 0;

    function automatic logic [3:0] opcode_of(input logic [15:0] inst);
        return inst[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [7:0] mov_imm_of(input logic [15:0] inst);
        return inst[IMM_HI:IMM_LO];
    endfunction

    function automatic logic [3:0] src_a_of(input logic [15:0] inst);
        return inst[SRC_A_HI:SRC_A_LO];
    endfunction

    function automatic logic [3:0] src_b_of(input logic [15:0] inst);
        return inst[SRC_B_HI:SRC_B_LO];
    endfunction

    function automatic logic [3:0] dst_of(input logic [15:0] inst);
        return inst[DST_HI:DST_LO];
    endfunction

    function automatic logic is_jump(input logic [15:0] inst);
        return opcode_of(inst) == OP_JMP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries with flush; pointers wrap naturally (DEPTH is a power of 2).
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage carries no reset; occupancy is governed solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues imem reads under a credit limit and queues
// {pc, inst} for execute; a redirect from execute flushes all wrong-path work.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int CRED_W = CNT_W + 1;
    localparam int ENT_W  = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic              vld_p1;
    logic [ADDR_W-1:0] pc_p1;
    logic              drop;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [CRED_W-1:0] credits;
    logic [ENT_W-1:0]  head;

    assign pop = out_valid && out_ready;

    // A pop this cycle frees its slot before the issued response can land, so it counts as a credit.
    assign credits   = CRED_W'(count) + CRED_W'(vld_p1) - CRED_W'(pop);
    assign imem_rd   = !reset && !redir_valid && (credits < CRED_W'(DEPTH));
    assign imem_addr = fetch_pc;

    // Issue stage -> response stage
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            vld_p1   <= 1'b0;
        end else if (redir_valid) begin
            fetch_pc <= redir_pc;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= imem_rd;
            if (imem_rd)
                fetch_pc <= fetch_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (imem_rd)
            pc_p1 <= fetch_pc;
    end

    // Response stage -> queue
    assign drop = vld_p1 && redir_valid;
    assign push = vld_p1 && !drop;

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redir_valid),
        .push      (push),
        .push_data ({pc_p1, imem_data}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_valid         = (count != '0);
    assign {out_pc, out_inst} = head;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed phases plus randomized ready/redirect/reset traffic,
// checked against a stream model (consecutive PCs from the latest reset/redirect target, inst = pc + 0x10).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_rd0, imem_rd1;
    logic [15:0] imem_addr0, imem_addr1;
    logic [15:0] imem_data0, imem_data1;
    logic        out_valid0, out_valid1;
    logic        out_ready0;
    logic        out_ready1;
    logic [15:0] out_inst0, out_inst1;
    logic [15:0] out_pc0, out_pc1;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic        redir_valid1;
    logic [15:0] redir_pc1;

    int checks = 0;
    int passed = 0;

    logic [15:0] exp0, exp1;
    logic        rst_pend = 1'b0;
    logic        hold_pend = 1'b0;
    logic [15:0] hold_pc, hold_inst;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(2), .RESET_PC(16'h0000)) dut0 (
        .clk(clk), .reset(reset), .imem_rd(imem_rd0), .imem_addr(imem_addr0), .imem_data(imem_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_inst(out_inst0), .out_pc(out_pc0),
        .redir_valid(redir_valid), .redir_pc(redir_pc)
    );

    fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(2), .RESET_PC(16'hFFFF)) dut1 (
        .clk(clk), .reset(reset), .imem_rd(imem_rd1), .imem_addr(imem_addr1), .imem_data(imem_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_inst(out_inst1), .out_pc(out_pc1),
        .redir_valid(redir_valid1), .redir_pc(redir_pc1)
    );

    // Registered instruction memory: mem[i] = 0x0010 + i; junk on cycles without a read.
    always @(posedge clk) begin
        imem_data0 <= imem_rd0 ? 16'h0010 + imem_addr0 : 16'($urandom);
        imem_data1 <= imem_rd1 ? 16'h0010 + imem_addr1 : 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Called after inputs for this cycle are driven; checks the cycle and advances to the next negedge.
    task automatic cycle();
        #1;
        if (rst_pend)
            chk("valid_after_reset", 32'(out_valid0), 32'(0));
        if (hold_pend) begin
            chk("hold_valid", 32'(out_valid0), 32'(1));
            chk("hold_pc", 32'(out_pc0), 32'(hold_pc));
            chk("hold_inst", 32'(out_inst0), 32'(hold_inst));
        end
        if (reset) begin
            chk("rd_in_reset", 32'(imem_rd0), 32'(0));
            exp0      = 16'h0000;
            exp1      = 16'hFFFF;
            rst_pend  = 1'b1;
            hold_pend = 1'b0;
        end else begin
            rst_pend = 1'b0;
            if (out_valid0 && out_ready0) begin
                chk("stream_pc", 32'(out_pc0), 32'(exp0));
                chk("stream_inst", 32'(out_inst0), 32'(16'(exp0 + 16'h0010)));
                exp0 = exp0 + 16'h0001;
            end
            if (out_valid1) begin
                chk("wrap_pc", 32'(out_pc1), 32'(exp1));
                chk("wrap_inst", 32'(out_inst1), 32'(16'(exp1 + 16'h0010)));
                exp1 = exp1 + 16'h0001;
            end
            if (redir_valid) begin
                chk("rd_in_redir", 32'(imem_rd0), 32'(0));
                exp0 = redir_pc;
            end
            hold_pend = out_valid0 && !out_ready0 && !redir_valid;
            hold_pc   = out_pc0;
            hold_inst = out_inst0;
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input logic [15:0] first_pc);
        int w;
        w = 0;
        #1;
        while (!out_valid0 && w < 6) begin
            cycle();
            #1;
            w++;
        end
        chk(tag, 32'(w < 6), 32'(1));
        chk({tag, "_pc"}, 32'(out_pc0), 32'(first_pc));
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        out_ready0   = 1'b1;
        out_ready1   = 1'b1;
        redir_valid  = 1'b0;
        redir_pc     = 16'h0000;
        redir_valid1 = 1'b0;
        redir_pc1    = 16'h0000;
        exp0         = 16'h0000;
        exp1         = 16'hFFFF;
        @(negedge clk);

        // Reset and startup latency, then one instruction per cycle.
        repeat (3) cycle();
        reset = 1'b0;
        #1;
        chk("start_rd", 32'(imem_rd0), 32'(1));
        chk("start_addr", 32'(imem_addr0), 32'(16'h0000));
        chk("start_valid", 32'(out_valid0), 32'(0));
        cycle();
        #1;
        chk("c1_valid", 32'(out_valid0), 32'(0));
        cycle();
        #1;
        chk("c2_valid", 32'(out_valid0), 32'(1));
        chk("c2_pc", 32'(out_pc0), 32'(16'h0000));
        chk("c2_inst", 32'(out_inst0), 32'(16'h0010));
        chk("c2_wrap_pc", 32'(out_pc1), 32'(16'hFFFF));
        cycle();
        repeat (10) begin
            #1;
            chk("throughput_valid", 32'(out_valid0), 32'(1));
            cycle();
        end

        // Back-pressure: queue fills, reads stop, head holds.
        out_ready0 = 1'b0;
        repeat (6) cycle();
        #1;
        chk("full_rd", 32'(imem_rd0), 32'(0));
        chk("full_valid", 32'(out_valid0), 32'(1));
        cycle();
        out_ready0 = 1'b1;
        repeat (6) cycle();

        // Redirect to 0005 while a read is in flight.
        redir_valid = 1'b1;
        redir_pc    = 16'h0005;
        cycle();
        redir_valid = 1'b0;
        #1;
        chk("redir_rd", 32'(imem_rd0), 32'(1));
        chk("redir_addr", 32'(imem_addr0), 32'(16'h0005));
        chk("redir_flushed", 32'(out_valid0), 32'(0));
        cycle();
        wait_valid("redir_latency", 16'h0005);
        repeat (4) cycle();

        // Redirect to 0000 together with a pop from a full queue.
        out_ready0 = 1'b0;
        repeat (4) cycle();
        out_ready0  = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 16'h0000;
        cycle();
        redir_valid = 1'b0;
        #1;
        chk("pop_redir_flushed", 32'(out_valid0), 32'(0));
        cycle();
        wait_valid("pop_redir_latency", 16'h0000);
        repeat (4) cycle();

        // Reset with a queued entry and a read in flight.
        out_ready0 = 1'b0;
        reset      = 1'b1;
        cycle();
        reset      = 1'b0;
        out_ready0 = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid0), 32'(0));
        chk("rst_rd", 32'(imem_rd0), 32'(1));
        chk("rst_addr", 32'(imem_addr0), 32'(16'h0000));
        chk("rst_wrap_valid", 32'(out_valid1), 32'(0));
        cycle();
        wait_valid("rst_latency", 16'h0000);
        repeat (4) cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(99) == 0);
            redir_valid = !reset && ($urandom_range(14) == 0);
            redir_pc    = ($urandom_range(3) == 0) ? 16'hFFFE + 16'($urandom_range(3)) : 16'($urandom);
            out_ready0  = ($urandom_range(9) < 7);
            cycle();
        end

        // The stream must resume after the random section.
        reset       = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 16'h1234;
        out_ready0  = 1'b1;
        cycle();
        redir_valid = 1'b0;
        cycle();
        wait_valid("final_latency", 16'h1234);
        repeat (4) cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
